cam_frame_writer: RTL and testbench

- Write-side producer for the camera frame buffer.
- Samples the OV7670 parallel bus (VSYNC, HREF, 8-bit data) and pairs bytes into RGB565 pixels.
- Crops a WIN_W x WIN_H window from the sensor frame and drives the buffer's port-A write interface (d_in_a, w_addr, w_en_a).
- Runs in the 25 MHz write domain; honours the reader's r_rd lock so a frame is never written while the buffer is being copied out.

---
 rtl/cam_cap_pkg.sv | 36 +++
 rtl/cam_byte_pack.sv | 29 ++
 rtl/cam_frame_writer.sv | 162 ++++++++++++++++
 tb/tb_cam_frame_writer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/cam_cap_pkg.sv
// rtl/cam_cap_pkg.sv - shared types and constants for the camera frame writer
package cam_cap_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    SYNC    = 2'd2,
    CAPTURE = 2'd3
  } cap_state_e;

  localparam int PIX_W  = 16;
  localparam int ADDR_W = 16;

  localparam int DEF_IMG_W = 640;
  localparam int DEF_IMG_H = 480;
  localparam int DEF_X_OFS = 192;
  localparam int DEF_Y_OFS = 112;
  localparam int DEF_WIN_W = 256;
  localparam int DEF_WIN_H = 256;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  // Gradient pattern: red/blue follow the column, green follows the row.
  function automatic logic [PIX_W-1:0] test_pixel(input logic [7:0] col, input logic [7:0] row);
    rgb565_t p;
    p.r = col[7:3];
    p.g = row[7:2];
    p.b = col[7:3];
    return p;
  endfunction

endpackage

// File: rtl/cam_byte_pack.sv
// rtl/cam_byte_pack.sv - pairs OV7670 bytes into 16-bit pixels
module cam_byte_pack
  import cam_cap_pkg::*;
(
  input  logic             w_clk,
  input  logic             rst,
  input  logic             href,
  input  logic [7:0]       data,
  output logic             pix_valid,
  output logic [PIX_W-1:0] pixel
);

  logic       phase;
  logic [7:0] hi;

  always_ff @(posedge w_clk) begin
    if (rst) begin
      phase <= 1'b0;
      hi    <= 8'd0;
    end else begin
      phase <= href ? ~phase : 1'b0;
      if (href && !phase) hi <= data;
    end
  end

  assign pix_valid = href & phase;
  assign pixel     = {hi, data};

endmodule

// File: rtl/cam_frame_writer.sv
// rtl/cam_frame_writer.sv - crops sensor frames into the frame buffer write port
// Optional CAP_TESTPAT_EN adds test_mode, replacing camera pixels by a gradient.
module cam_frame_writer
  import cam_cap_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int X_OFS = DEF_X_OFS,
  parameter int Y_OFS = DEF_Y_OFS,
  parameter int WIN_W = DEF_WIN_W,
  parameter int WIN_H = DEF_WIN_H
) (
  input  logic              w_clk,
  input  logic              rst,
  input  logic              cap_en,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  input  logic              r_rd,
`ifdef CAP_TESTPAT_EN
  input  logic              test_mode,
`endif
  output logic [PIX_W-1:0]  d_in_a,
  output logic [ADDR_W-1:0] w_addr,
  output logic              w_en_a,
  output logic              frame_done,
  output logic              busy,
  output logic [7:0]        drop_cnt
);

  localparam logic [15:0]     IMG_W_L = 16'(IMG_W);
  localparam logic [15:0]     IMG_H_L = 16'(IMG_H);
  localparam logic [15:0]     X_OFS_L = 16'(X_OFS);
  localparam logic [15:0]     Y_OFS_L = 16'(Y_OFS);
  localparam logic [15:0]     X_END_L = 16'(X_OFS + WIN_W);
  localparam logic [15:0]     Y_END_L = 16'(Y_OFS + WIN_H);
  localparam logic [ADDR_W:0] TOTAL   = (ADDR_W+1)'(WIN_W * WIN_H);

  cap_state_e state, state_n;

  logic              vsync_q, href_q;
  logic              vs_rise, vs_fall, href_fall;
  logic [15:0]       px, ln;
  logic [ADDR_W:0]   wcnt;
  logic              pix_valid;
  logic [PIX_W-1:0]  pixel, pix_out;
  logic              in_win, wr_fire;
  logic              clr_cnt, drop_inc, done_set, abort;
  logic              w_en_q;

  cam_byte_pack u_pack (
    .w_clk     (w_clk),
    .rst       (rst),
    .href      (cam_href),
    .data      (cam_data),
    .pix_valid (pix_valid),
    .pixel     (pixel)
  );

  assign vs_rise   = cam_vsync & ~vsync_q;
  assign vs_fall   = ~cam_vsync & vsync_q;
  assign href_fall = ~cam_href & href_q;

  always_ff @(posedge w_clk) begin
    if (rst) begin
      state   <= IDLE;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
    end else begin
      state   <= state_n;
      vsync_q <= cam_vsync;
      href_q  <= cam_href;
    end
  end

  always_comb begin
    state_n  = state;
    clr_cnt  = 1'b0;
    drop_inc = 1'b0;
    done_set = 1'b0;
    abort    = 1'b0;
    case (state)
      IDLE:    if (cap_en) state_n = ARMED;
      ARMED:   if (cam_vsync) state_n = SYNC;
      SYNC: begin
        if (vs_fall) begin
          if (r_rd) begin
            drop_inc = 1'b1;
            state_n  = ARMED;
          end else begin
            clr_cnt = 1'b1;
            state_n = CAPTURE;
          end
        end
      end
      CAPTURE: begin
        // The reader lock wins over a coincident end of frame.
        if (r_rd) begin
          abort    = 1'b1;
          drop_inc = 1'b1;
          state_n  = ARMED;
        end else if (vs_rise) begin
          state_n = cap_en ? ARMED : IDLE;
          if (wcnt == TOTAL) done_set = 1'b1;
          else               drop_inc = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign in_win  = (px >= X_OFS_L) && (px < X_END_L) && (ln >= Y_OFS_L) && (ln < Y_END_L);
  assign wr_fire = (state == CAPTURE) && !r_rd && pix_valid && in_win && (wcnt != TOTAL);

`ifdef CAP_TESTPAT_EN
  logic [7:0] col, row;
  assign col     = px[7:0] - X_OFS_L[7:0];
  assign row     = ln[7:0] - Y_OFS_L[7:0];
  assign pix_out = test_mode ? test_pixel(col, row) : pixel;
`else
  assign pix_out = pixel;
`endif

  always_ff @(posedge w_clk) begin
    if (rst || clr_cnt) begin
      px   <= 16'd0;
      ln   <= 16'd0;
      wcnt <= '0;
    end else if (state == CAPTURE) begin
      if (href_fall) begin
        px <= 16'd0;
        if (ln != IMG_H_L) ln <= ln + 16'd1;
      end else if (pix_valid && px != IMG_W_L) begin
        px <= px + 16'd1;
      end
      if (wr_fire) wcnt <= wcnt + 1'b1;
    end
  end

  always_ff @(posedge w_clk) begin
    if (rst) begin
      w_en_q     <= 1'b0;
      d_in_a     <= '0;
      w_addr     <= '0;
      frame_done <= 1'b0;
      drop_cnt   <= 8'd0;
    end else begin
      w_en_q     <= wr_fire;
      frame_done <= done_set;
      if (wr_fire) begin
        d_in_a <= pix_out;
        w_addr <= wcnt[ADDR_W-1:0];
      end
      if (drop_inc && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // A write already registered is killed as soon as the reader locks or reset hits.
  assign w_en_a = w_en_q & ~abort & ~rst;
  assign busy   = (state == SYNC) || (state == CAPTURE);

endmodule

// File: tb/tb_cam_frame_writer.sv
// tb/tb_cam_frame_writer.sv - randomized self-checking bench for cam_frame_writer
module tb_cam_frame_writer;

  localparam int IW = 16;
  localparam int IH = 12;
  localparam int XO = 4;
  localparam int YO = 3;
  localparam int WW = 8;
  localparam int WH = 6;

  logic        w_clk = 1'b0;
  logic        rst, cap_en, cam_vsync, cam_href, r_rd;
  logic [7:0]  cam_data;
  logic        test_mode = 1'b0;
  logic [15:0] d_in_a, w_addr;
  logic        w_en_a, frame_done, busy;
  logic [7:0]  drop_cnt;

  cam_frame_writer #(
    .IMG_W(IW), .IMG_H(IH), .X_OFS(XO), .Y_OFS(YO), .WIN_W(WW), .WIN_H(WH)
  ) dut (
    .w_clk      (w_clk),
    .rst        (rst),
    .cap_en     (cap_en),
    .cam_vsync  (cam_vsync),
    .cam_href   (cam_href),
    .cam_data   (cam_data),
    .r_rd       (r_rd),
`ifdef CAP_TESTPAT_EN
    .test_mode  (test_mode),
`endif
    .d_in_a     (d_in_a),
    .w_addr     (w_addr),
    .w_en_a     (w_en_a),
    .frame_done (frame_done),
    .busy       (busy),
    .drop_cnt   (drop_cnt)
  );

  always #20 w_clk = ~w_clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  logic [15:0] pix [IH][IW];
  bit          cap_active, pend_we, rst_chk, dut_enabled;
  logic [15:0] pend_addr, pend_data;
  int          done_seen, exp_done, exp_drop, wr_seen;

  // One sensor cycle: drive, check the write due from the previous byte, predict the next.
  task automatic cycle(input bit hr, input logic [7:0] d, input int line, input int b, input int ev);
    @(posedge w_clk);
    #1;
    cam_href = hr;
    cam_data = d;
    rst      = (ev == 2);
    if (ev == 1) begin
      r_rd       = 1'b1;
      pend_we    = 1'b0;
      cap_active = 1'b0;
    end
    if (ev == 2) cap_active = 1'b0;
    #1;
    if (pend_we || w_en_a) begin
      chk("w_en_a", w_en_a, pend_we);
      if (pend_we) begin
        chk("w_addr", w_addr, pend_addr);
        chk("d_in_a", d_in_a, pend_data);
      end
    end
    if (ev == 1) chk("abort_wen", w_en_a, 0);
    if (w_en_a) wr_seen++;
    if (frame_done) done_seen++;
    if (rst_chk) begin
      chk("rst_wen", w_en_a, 0);
      chk("rst_din", d_in_a, 0);
      chk("rst_addr", w_addr, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_drop", drop_cnt, 0);
      rst_chk = 1'b0;
    end
    if (ev == 2) rst_chk = 1'b1;
    pend_we = 1'b0;
    if (cap_active && hr && (b % 2 == 1)) begin
      int p;
      p = b / 2;
      if (p >= XO && p < XO + WW && line >= YO && line < YO + WH) begin
        pend_we   = 1'b1;
        pend_addr = 16'((line - YO) * WW + (p - XO));
        pend_data = pix[line][p];
      end
    end
  endtask

  // mode: 0 normal, 1 r_rd at VSYNC fall, 2 r_rd abort at (ev_line, ev_px),
  //       3 reset at (ev_line, ev_px), 4 cap_en cleared at start of ev_line
  task automatic run_frame(input int nlines, input int mode, input int ev_line, input int ev_px, input bit first);
    bit   captured;
    int   exp_wr, ev;
    logic [15:0] w;
    for (int l = 0; l < IH; l++)
      for (int p = 0; p < IW; p++)
        pix[l][p] = 16'($urandom);
    if (first) pix[YO][XO] = 16'hF81F;
    wr_seen  = 0;
    captured = dut_enabled && (mode != 1);
    for (int i = 0; i < 6; i++) cycle(1'b0, 8'd0, 0, 0, 0);
    if (mode == 1) begin
      r_rd = 1'b1;
      if (dut_enabled) exp_drop++;
    end
    cam_vsync  = 1'b0;
    cap_active = captured;
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'd0, 0, 0, 0);
    for (int l = 0; l < nlines; l++) begin
      if (mode == 4 && l == ev_line) cap_en = 1'b0;
      for (int b = 0; b < 2 * IW; b++) begin
        ev = 0;
        if (mode == 2 && l == ev_line && b == 2 * ev_px + 2) ev = 1;
        if (mode == 3 && l == ev_line && b == 2 * ev_px + 1) ev = 2;
        w = pix[l][b/2];
        cycle(1'b1, (b % 2 == 0) ? w[15:8] : w[7:0], l, b, ev);
      end
      for (int i = 0; i < 4; i++) cycle(1'b0, 8'd0, l, 0, 0);
    end
    cam_vsync = 1'b1;
    r_rd      = 1'b0;
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'd0, 0, 0, 0);
    cap_active = 1'b0;

    exp_wr = 0;
    if (captured && (mode == 0 || mode == 4)) begin
      int rows;
      rows   = (nlines < YO + WH ? nlines : YO + WH) - YO;
      exp_wr = (rows > 0 ? rows : 0) * WW;
      if (nlines >= YO + WH) exp_done++;
      else                   exp_drop++;
    end
    if (captured && (mode == 2 || mode == 3)) exp_wr = (ev_line - YO) * WW + (ev_px - XO);
    if (captured && mode == 2) exp_drop++;
    if (mode == 3) exp_drop = 0;
    if (mode == 4) dut_enabled = 1'b0;

    chk("write_count", wr_seen, exp_wr);
    chk("frame_done_count", done_seen, exp_done);
    chk("drop_cnt", drop_cnt, exp_drop);
    chk("busy_after_frame", busy, dut_enabled);
  endtask

  initial begin
    rst = 1'b1; cap_en = 1'b0; cam_vsync = 1'b1; cam_href = 1'b0; cam_data = 8'd0; r_rd = 1'b0;
    cap_active = 0; pend_we = 0; rst_chk = 0; dut_enabled = 0;
    done_seen = 0; exp_done = 0; exp_drop = 0; wr_seen = 0;
    repeat (4) @(posedge w_clk);
    #1;
    chk("reset_wen", w_en_a, 0);
    chk("reset_din", d_in_a, 0);
    chk("reset_addr", w_addr, 0);
    chk("reset_done", frame_done, 0);
    chk("reset_busy", busy, 0);
    chk("reset_drop", drop_cnt, 0);
    rst = 1'b0;
    cap_en = 1'b1;
    dut_enabled = 1'b1;

    run_frame(IH, 0, 0, 0, 1'b1);
    run_frame(IH, 1, 0, 0, 1'b0);
    run_frame(IH, 0, 0, 0, 1'b0);
    run_frame(IH, 2, 5, 6, 1'b0);
    run_frame(IH, 0, 0, 0, 1'b0);
    run_frame(5, 0, 0, 0, 1'b0);
    run_frame(IH, 4, 6, 0, 1'b0);
    run_frame(IH, 0, 0, 0, 1'b0);
    cap_en = 1'b1;
    dut_enabled = 1'b1;
    run_frame(IH, 0, 0, 0, 1'b0);
    run_frame(IH, 3, 4, 5, 1'b0);
    run_frame(IH, 0, 0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
